// File: rtl/capture_pkg.sv
// Shared definitions for the capture sequencer: state encoding and default widths.
package capture_pkg;

  localparam int unsigned DEFAULT_DIVIDER_WIDTH = 24;
  localparam int unsigned DEFAULT_COUNT_WIDTH   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/sample_ticker.sv
// Reloadable down-counter: tick is high whenever the count is zero; on a tick the
// counter reloads, otherwise it decrements while enabled.
module sample_ticker #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] reload,
  output logic             tick
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      if (r_count == '0) r_count <= reload;
      else               r_count <= r_count - 1'b1;
    end
  end

  assign tick = (r_count == '0);

endmodule

// File: rtl/capture_sequencer.sv
// Capture sequencer: on start, optionally waits for a trigger, then issues a strobe
// every (divider + 1) cycles until the latched number of samples has been taken.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int unsigned DIVIDER_WIDTH = DEFAULT_DIVIDER_WIDTH,
  parameter int unsigned COUNT_WIDTH   = DEFAULT_COUNT_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [DIVIDER_WIDTH-1:0] clock_divider,
  input  logic [COUNT_WIDTH-1:0]   sample_count,
  input  logic                     trigger_enable,
  input  logic                     trigger,
  output logic                     busy,
  output logic                     armed,
  output logic                     sample_strobe,
  output logic [COUNT_WIDTH-1:0]   sample_index,
  output logic                     done,
  output state_t                   dbg_state
);

  localparam logic [COUNT_WIDTH-1:0] ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                   r_state;
  state_t                   w_next;
  logic [DIVIDER_WIDTH-1:0] r_divider;
  logic [COUNT_WIDTH-1:0]   r_count;
  logic [COUNT_WIDTH-1:0]   r_index;
  logic                     r_trig_en;
  logic                     w_tick;
  logic                     w_strobe;
  logic                     w_last;
  logic                     w_accept;

  // The ticker is held at zero outside CAPTURE, so the first capture cycle strobes.
  sample_ticker #(.WIDTH(DIVIDER_WIDTH)) u_ticker (
    .clock  (clock),
    .reset  (reset),
    .clear  (r_state != ST_CAPTURE),
    .enable (r_state == ST_CAPTURE),
    .reload (r_divider),
    .tick   (w_tick)
  );

  assign w_accept = (r_state == ST_IDLE) && start && !abort;
  assign w_strobe = (r_state == ST_CAPTURE) && w_tick;
  // r_count is nonzero whenever CAPTURE is reached, so the subtraction cannot underflow.
  assign w_last   = w_strobe && (r_index == (r_count - ONE));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (sample_count == '0)  w_next = ST_DONE;
          else if (trigger_enable) w_next = ST_ARMED;
          else                     w_next = ST_CAPTURE;
        end
      end
      ST_ARMED: begin
        if (abort)                      w_next = ST_IDLE;
        else if (trigger && r_trig_en)  w_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (abort)       w_next = ST_IDLE;
        else if (w_last) w_next = ST_DONE;
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_divider <= '0;
      r_count   <= '0;
      r_trig_en <= 1'b0;
      r_index   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_divider <= clock_divider;
        r_count   <= sample_count;
        r_trig_en <= trigger_enable;
        r_index   <= '0;
      end else if (w_strobe && !abort) begin
        r_index <= r_index + ONE;
      end
    end
  end

  assign busy          = (r_state != ST_IDLE);
  assign armed         = (r_state == ST_ARMED);
  assign sample_strobe = w_strobe;
  assign sample_index  = r_index;
  assign done          = (r_state == ST_DONE);
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: directed and randomized captures
// compared cycle by cycle against a timeline computed from the sample schedule.
module tb_capture_sequencer;
  import capture_pkg::*;

  localparam int DW = 24;
  localparam int CW = 8;

  logic          clock;
  logic          reset;
  logic          start;
  logic          abort;
  logic [DW-1:0] clock_divider;
  logic [CW-1:0] sample_count;
  logic          trigger_enable;
  logic          trigger;
  logic          busy;
  logic          armed;
  logic          sample_strobe;
  logic [CW-1:0] sample_index;
  logic          done;
  state_t        dbg_state;

  int tests_run;
  int tests_failed;

  capture_sequencer #(.DIVIDER_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .clock_divider  (clock_divider),
    .sample_count   (sample_count),
    .trigger_enable (trigger_enable),
    .trigger        (trigger),
    .busy           (busy),
    .armed          (armed),
    .sample_strobe  (sample_strobe),
    .sample_index   (sample_index),
    .done           (done),
    .dbg_state      (dbg_state)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"},   int'(busy),          0);
    check({tag, " armed"},  int'(armed),         0);
    check({tag, " strobe"}, int'(sample_strobe), 0);
    check({tag, " done"},   int'(done),          0);
  endtask

  // Reference model: a capture started at cycle 0 enters CAPTURE at cycle c0
  // (1, or one cycle after the trigger is seen) and strobes at c0 + k*(d+1).
  // Called at a negedge with the DUT idle; leaves at a negedge with the DUT idle.
  task automatic run_case(input string tag, input int d, input int n, input bit te,
                          input int t_on, input int abort_at, input int mid_start);
    int  c0;
    int  last;
    int  end_c;
    bit  live;
    bit  e_armed;
    bit  e_strobe;
    bit  completed;
    c0        = te ? t_on + 1 : 1;
    last      = (n == 0) ? 0 : c0 + (n - 1) * (d + 1);
    end_c     = (n == 0) ? 1 : last + 1;
    completed = (abort_at < 0) || (abort_at >= end_c);
    for (int c = 0; c <= end_c + 1; c++) begin
      live     = (c >= 1) && (c <= end_c) && !(abort_at >= 0 && c > abort_at);
      e_armed  = live && te && (n != 0) && (c < c0);
      e_strobe = live && (n != 0) && (c >= c0) && (c <= last) && (((c - c0) % (d + 1)) == 0);
      check({tag, " busy"},   int'(busy),          int'(live));
      check({tag, " armed"},  int'(armed),         int'(e_armed));
      check({tag, " strobe"}, int'(sample_strobe), int'(e_strobe));
      check({tag, " done"},   int'(done),          int'(live && (c == end_c)));
      if (e_strobe) check({tag, " index"}, int'(sample_index), (c - c0) / (d + 1));
      if (c == end_c + 1 && completed) check({tag, " final index"}, int'(sample_index), n);
      if (c == 0) begin
        start          = 1'b1;
        clock_divider  = DW'(d);
        sample_count   = CW'(n);
        trigger_enable = te;
      end else begin
        start          = (c == mid_start) && (c <= end_c) && (abort_at < 0 || c < abort_at);
        clock_divider  = DW'($urandom_range(0, 7));
        sample_count   = CW'($urandom_range(0, 255));
        trigger_enable = 1'($urandom_range(0, 1));
      end
      abort   = (c == abort_at);
      trigger = te ? (c >= t_on) : 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    start   = 1'b0;
    abort   = 1'b0;
    trigger = 1'b0;
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    reset          = 1'b1;
    start          = 1'b0;
    abort          = 1'b0;
    clock_divider  = '0;
    sample_count   = '0;
    trigger_enable = 1'b0;
    trigger        = 1'b0;
    repeat (3) @(negedge clock);

    check_idle_outputs("reset");
    check("reset index", int'(sample_index), 0);
    check("reset state", int'(dbg_state), int'(ST_IDLE));
    reset = 1'b0;
    @(negedge clock);

    run_case("div2_n3",    2, 3, 1'b0, 1, -1, -1);
    run_case("div0_n4",    0, 4, 1'b0, 1, -1, -1);
    run_case("armed_wait", 1, 2, 1'b1, 11, -1, -1);
    run_case("n0",         3, 0, 1'b0, 1, -1, -1);
    run_case("n0_armed",   3, 0, 1'b1, 2, -1, -1);
    run_case("abort_n5",   1, 5, 1'b0, 1, 4, 2);
    run_case("after_abort", 1, 5, 1'b0, 1, -1, 3);
    run_case("abort_armed", 0, 3, 1'b1, 6, 3, 2);
    run_case("max_count",  0, (1 << CW) - 1, 1'b0, 1, -1, 100);
    run_case("max_div",    (1 << DW) - 1, 1, 1'b0, 1, -1, 1);

    // start together with abort in IDLE must not begin a capture
    start        = 1'b1;
    abort        = 1'b1;
    sample_count = CW'(2);
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    check_idle_outputs("start_abort c1");
    @(negedge clock);
    check_idle_outputs("start_abort c2");

    // reset in CAPTURE clears everything at the next edge
    start          = 1'b1;
    clock_divider  = DW'(2);
    sample_count   = CW'(3);
    trigger_enable = 1'b0;
    @(negedge clock);
    start = 1'b0;
    check("rst_mid strobe0", int'(sample_strobe), 1);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    check("rst_mid strobe1", int'(sample_strobe), 1);
    check("rst_mid index1", int'(sample_index), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_idle_outputs("rst_mid");
    check("rst_mid index", int'(sample_index), 0);
    check("rst_mid state", int'(dbg_state), int'(ST_IDLE));
    @(negedge clock);
    check_idle_outputs("rst_mid after");

    for (int i = 0; i < 25; i++) begin
      int d;
      int n;
      bit te;
      int ab;
      d  = $urandom_range(0, 4);
      n  = $urandom_range(0, 6);
      te = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : -1;
      run_case("rand", d, n, te, $urandom_range(1, 5), ab, $urandom_range(1, 10));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
